output_scheduler: RTL and testbench

OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

---
 rtl/output_scheduler_if.sv | 31 +++
 rtl/output_scheduler.sv | 105 ++++++++++
 tb/tb_output_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_scheduler_if.sv
// Tooth-anchored event scheduler bus: tooth stream, event configuration and output status.
interface output_scheduler_if #(
    parameter int TIMER_W = 24,
    parameter int TOOTH_W = 8
);
    logic               en;
    logic [TOOTH_W-1:0] tooth_num;
    logic               tooth_edge;
    logic               sync_lost;
    logic [TOOTH_W-1:0] start_tooth;
    logic [TOOTH_W-1:0] end_tooth;
    logic [TIMER_W-1:0] start_counts;
    logic [TIMER_W-1:0] end_counts;
    logic [TIMER_W-1:0] max_on_counts;
    logic               invert;
    logic               out;
    logic               active;
    logic               busy;
    logic               fault;

    modport master (
        output en, tooth_num, tooth_edge, sync_lost, start_tooth, end_tooth,
               start_counts, end_counts, max_on_counts, invert,
        input  out, active, busy, fault
    );
    modport slave (
        input  en, tooth_num, tooth_edge, sync_lost, start_tooth, end_tooth,
               start_counts, end_counts, max_on_counts, invert,
        output out, active, busy, fault
    );
endinterface

// File: rtl/output_scheduler.sv
// Schedules one output pulse per armed event: start/end delays counted from anchor teeth,
// with an optional on-time limit and a level-sensitive abort.
module output_scheduler #(
    parameter int TIMER_W = 24,
    parameter int TOOTH_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    output_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, ENDING} state_t;

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    state_t             state, state_nx;
    logic [TOOTH_W-1:0] end_tooth_q;
    logic [TIMER_W-1:0] end_counts_q, max_q;
    logic [TIMER_W-1:0] st_cnt, et_cnt, on_cnt;
    logic               st_run, active_q, fault_q;
    logic               match_start, match_end, same_tooth;
    logic               st_exp, et_exp, on_limit, on_sat;

    assign match_start = bus.en && bus.tooth_edge && (bus.tooth_num == bus.start_tooth);
    assign same_tooth  = (bus.start_tooth == bus.end_tooth);
    assign match_end   = bus.tooth_edge && (bus.tooth_num == end_tooth_q);
    assign st_exp      = st_run && (st_cnt == '0);
    assign et_exp      = (state == ENDING) && (et_cnt == '0);
    assign on_sat      = &on_cnt;
    // one extra bit so the compare is exact even when max_q is all ones
    assign on_limit    = active_q && (max_q != '0) &&
                         (({1'b0, on_cnt} + {{TIMER_W{1'b0}}, 1'b1}) == {1'b0, max_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!bus.sync_lost && match_start)
                         state_nx = same_tooth ? ENDING : ARMED;
            ARMED:   if (bus.sync_lost || on_limit) state_nx = IDLE;
                     else if (match_end)            state_nx = ENDING;
            ENDING:  if (bus.sync_lost || on_limit || et_exp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.active = active_q;
        bus.fault  = fault_q;
        bus.out    = active_q ^ bus.invert;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_tooth_q  <= '0;
            end_counts_q <= '0;
            max_q        <= '0;
            st_cnt       <= '0;
            et_cnt       <= '0;
            on_cnt       <= '0;
            st_run       <= 1'b0;
            active_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else if (bus.sync_lost) begin
            active_q <= 1'b0;
            st_run   <= 1'b0;
            st_cnt   <= '0;
            et_cnt   <= '0;
            on_cnt   <= '0;
        end else if (state == IDLE) begin
            if (match_start) begin
                end_tooth_q  <= bus.end_tooth;
                end_counts_q <= bus.end_counts;
                max_q        <= bus.max_on_counts;
                st_cnt       <= bus.start_counts;
                st_run       <= 1'b1;
                fault_q      <= 1'b0;
                on_cnt       <= '0;
                et_cnt       <= same_tooth ? bus.end_counts : '0;
            end
        end else if (on_limit || et_exp) begin
            // end expiry at the same edge as start expiry wins: the pulse is suppressed
            active_q <= 1'b0;
            if (on_limit) fault_q <= 1'b1;
            st_run   <= 1'b0;
            st_cnt   <= '0;
            et_cnt   <= '0;
            on_cnt   <= '0;
        end else begin
            if (st_exp) begin
                active_q <= 1'b1;
                st_run   <= 1'b0;
            end else if (st_run) begin
                st_cnt <= st_cnt - ONE;
            end
            if (state == ENDING)  et_cnt <= et_cnt - ONE;
            else if (match_end)   et_cnt <= end_counts_q;
            if (active_q && !on_sat) on_cnt <= on_cnt + ONE;
        end
    end
endmodule

// File: tb/tb_output_scheduler.sv
// Directed scenarios plus randomized traffic against a deadline-based reference model.
module tb_output_scheduler;
    localparam int TW  = 24;
    localparam int TTW = 8;
    localparam int INF = 32'h7fffffff;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    output_scheduler_if #(.TIMER_W(TW), .TOOTH_W(TTW)) bus ();
    output_scheduler #(.TIMER_W(TW), .TOOTH_W(TTW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0, errors = 0, cyc = 0, mm = 0;

    // reference model: absolute edge numbers at which things happen
    bit           m_busy, m_active, m_fault;
    int           rise_at, end_at, lim_at, m_E, m_max;
    logic [TTW-1:0] m_endt;

    int r_rise, r_fall, r_bfall;
    bit p_active, p_busy;

    task automatic model_reset();
        m_busy = 0; m_active = 0; m_fault = 0;
        rise_at = INF; end_at = INF; lim_at = INF;
        m_E = 0; m_max = 0; m_endt = '0;
        p_active = 0; p_busy = 0;
    endtask

    task automatic model_idle();
        m_busy = 0; m_active = 0;
        rise_at = INF; end_at = INF; lim_at = INF;
    endtask

    task automatic model_step();
        if (bus.sync_lost) begin
            model_idle();
        end else if (!m_busy) begin
            if (bus.en && bus.tooth_edge && bus.tooth_num == bus.start_tooth) begin
                m_busy  = 1;
                m_fault = 0;
                m_endt  = bus.end_tooth;
                m_E     = int'(bus.end_counts);
                m_max   = int'(bus.max_on_counts);
                rise_at = cyc + int'(bus.start_counts) + 1;
                lim_at  = INF;
                end_at  = (bus.start_tooth == bus.end_tooth) ? cyc + m_E + 1 : INF;
            end
        end else begin
            if (end_at == INF && bus.tooth_edge && bus.tooth_num == m_endt)
                end_at = cyc + m_E + 1;
            if (lim_at == cyc) begin
                model_idle();
                m_fault = 1;
            end else if (end_at == cyc) begin
                model_idle();
            end else if (rise_at == cyc) begin
                m_active = 1;
                if (m_max != 0) lim_at = cyc + m_max;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        if (bus.active !== m_active || bus.busy !== m_busy || bus.fault !== m_fault ||
            bus.out !== (m_active ^ bus.invert)) mm++;
        if (bus.active && !p_active) r_rise = cyc;
        if (!bus.active && p_active) r_fall = cyc;
        if (!bus.busy && p_busy)     r_bfall = cyc;
        p_active = bus.active;
        p_busy   = bus.busy;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [TTW-1:0] t);
        bus.tooth_num  = t;
        bus.tooth_edge = 1'b1;
        tick();
        bus.tooth_edge = 1'b0;
    endtask

    task automatic set_cfg(input int st, input int et, input int s, input int e, input int mx);
        bus.start_tooth   = TTW'(st);
        bus.end_tooth     = TTW'(et);
        bus.start_counts  = TW'(s);
        bus.end_counts    = TW'(e);
        bus.max_on_counts = TW'(mx);
        r_rise = -1; r_fall = -1; r_bfall = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        idle(3);
        checks++;
        if ({bus.active, bus.busy, bus.fault, bus.out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got a/b/f/o=%b required 0000", {bus.active, bus.busy, bus.fault, bus.out});
        end
        bus.invert = 1'b1;
        #1;
        checks++;
        if (bus.out !== 1'b1) begin
            errors++;
            $display("FAIL reset_out_invert got %b required 1", bus.out);
        end
        bus.invert = 1'b0;
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_same_tooth();
        int e0, m0;
        m0 = mm;
        set_cfg(5, 5, 10, 30, 0);
        pulse(5);
        e0 = cyc;
        idle(40);
        checks++;
        if (r_rise - e0 !== 11) begin errors++; $display("FAIL same_rise got E%0d required E11", r_rise - e0); end
        checks++;
        if (r_fall - e0 !== 31) begin errors++; $display("FAIL same_fall got E%0d required E31", r_fall - e0); end
        checks++;
        if (r_bfall - e0 !== 31) begin errors++; $display("FAIL same_busy got E%0d required E31", r_bfall - e0); end
        checks++;
        if (mm !== m0) begin errors++; $display("FAIL same_model got %0d cycle diffs required 0", mm - m0); end
    endtask

    task automatic test_split_wrap();
        int e0, m0;
        m0 = mm;
        set_cfg(200, 3, 4, 6, 0);
        pulse(200);
        e0 = cyc;
        idle(100);
        pulse(200);
        idle(398);
        pulse(3);
        idle(10);
        checks++;
        if (r_rise - e0 !== 5) begin errors++; $display("FAIL split_rise got E%0d required E5", r_rise - e0); end
        checks++;
        if (r_fall - e0 !== 507) begin errors++; $display("FAIL split_fall got E%0d required E507", r_fall - e0); end
        checks++;
        if (mm !== m0) begin errors++; $display("FAIL split_model got %0d cycle diffs required 0", mm - m0); end
    endtask

    task automatic test_on_limit();
        int e0, m0;
        m0 = mm;
        set_cfg(7, 7, 2, 100, 20);
        pulse(7);
        e0 = cyc;
        idle(30);
        checks++;
        if (r_rise - e0 !== 3 || r_fall - e0 !== 23) begin
            errors++; $display("FAIL limit_window got E%0d..E%0d required E3..E23", r_rise - e0, r_fall - e0);
        end
        checks++;
        if (bus.fault !== 1'b1 || r_bfall - e0 !== 23) begin
            errors++; $display("FAIL limit_fault got fault=%b idle@E%0d required 1 idle@E23", bus.fault, r_bfall - e0);
        end
        pulse(7);
        checks++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL limit_rearm got fault=%b busy=%b required 0 1", bus.fault, bus.busy);
        end
        idle(30);
        checks++;
        if (mm !== m0) begin errors++; $display("FAIL limit_model got %0d cycle diffs required 0", mm - m0); end
    endtask

    task automatic test_suppressed();
        int e0, m0;
        m0 = mm;
        set_cfg(9, 9, 8, 8, 0);
        pulse(9);
        e0 = cyc;
        idle(15);
        checks++;
        if (r_rise !== -1) begin errors++; $display("FAIL supp_rise got E%0d required none", r_rise - e0); end
        checks++;
        if (r_bfall - e0 !== 9 || bus.fault !== 1'b0) begin
            errors++; $display("FAIL supp_busy got idle@E%0d fault=%b required E9 0", r_bfall - e0, bus.fault);
        end
        checks++;
        if (mm !== m0) begin errors++; $display("FAIL supp_model got %0d cycle diffs required 0", mm - m0); end
    endtask

    task automatic test_abort();
        int e0, ea, m0;
        m0 = mm;
        set_cfg(4, 4, 3, 50, 0);
        pulse(4);
        e0 = cyc;
        idle(5);
        pulse(4);
        idle(3);
        bus.sync_lost = 1'b1;
        tick();
        bus.sync_lost = 1'b0;
        ea = cyc;
        checks++;
        if ({bus.active, bus.busy, bus.fault} !== 3'b000 || r_fall !== ea) begin
            errors++; $display("FAIL abort_state got a/b/f=%b fall@%0d required 000 @%0d", {bus.active, bus.busy, bus.fault}, r_fall, ea);
        end
        idle(60);
        checks++;
        if (r_rise - e0 !== 4) begin errors++; $display("FAIL abort_rise got E%0d required E4", r_rise - e0); end
        checks++;
        if (mm !== m0) begin errors++; $display("FAIL abort_model got %0d cycle diffs required 0", mm - m0); end
    endtask

    task automatic test_polarity_reset();
        bus.invert = 1'b1;
        idle(2);
        checks++;
        if (bus.out !== 1'b1) begin errors++; $display("FAIL pol_idle got %b required 1", bus.out); end
        set_cfg(6, 6, 2, 20, 0);
        pulse(6);
        idle(4);
        checks++;
        if (bus.active !== 1'b1 || bus.out !== 1'b0) begin
            errors++; $display("FAIL pol_active got a=%b out=%b required 1 0", bus.active, bus.out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.active !== 1'b0 || bus.out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL pol_reset got a=%b out=%b busy=%b required 0 1 0", bus.active, bus.out, bus.busy);
        end
        model_reset();
        tick();
        reset_n = 1'b1;
        idle(25);
        checks++;
        if (bus.busy !== 1'b0 || bus.active !== 1'b0) begin
            errors++; $display("FAIL reset_rearm got busy=%b a=%b required 0 0", bus.busy, bus.active);
        end
        bus.invert = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            bus.tooth_edge    = ($urandom % 3) == 0;
            bus.tooth_num     = TTW'($urandom % 6);
            bus.en            = ($urandom % 4) != 0;
            bus.sync_lost     = ($urandom % 150) == 0;
            if (($urandom % 50) == 0) bus.invert = ~bus.invert;
            bus.start_tooth   = TTW'($urandom % 6);
            bus.end_tooth     = TTW'($urandom % 6);
            bus.start_counts  = TW'($urandom % 12);
            bus.end_counts    = TW'($urandom % 16);
            bus.max_on_counts = (($urandom % 3) == 0) ? TW'(0) : TW'($urandom_range(1, 13));
            tick();
            checks++;
            if (bus.active !== m_active || bus.busy !== m_busy || bus.fault !== m_fault ||
                bus.out !== (m_active ^ bus.invert)) begin
                errors++;
                $display("FAIL rand_cycle %0d got a/b/f/o=%b%b%b%b required %b%b%b%b", cyc,
                         bus.active, bus.busy, bus.fault, bus.out,
                         m_active, m_busy, m_fault, m_active ^ bus.invert);
            end
        end
        bus.tooth_edge = 1'b0;
        bus.sync_lost  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.en = 1'b1; bus.tooth_num = '0; bus.tooth_edge = 1'b0; bus.sync_lost = 1'b0;
        bus.start_tooth = '0; bus.end_tooth = '0; bus.start_counts = '0; bus.end_counts = '0;
        bus.max_on_counts = '0; bus.invert = 1'b0;
        test_reset();
        test_same_tooth();
        test_split_wrap();
        test_on_limit();
        test_suppressed();
        test_abort();
        test_polarity_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
